multicycle_ctrl: RTL and testbench

Multicycle MIPS control FSM that drives the ALU's control and operand-select interface and consumes its Zero flag. Each instruction is sequenced through FETCH/DECODE/EXECUTE/MEM/WB phases, with the single shared ALU reused for PC+4, branch target, address and result computation. Memory accesses stall on a MemReady handshake. AluCtrl codes are the shared `ALUOp_*` encodings from ctrl_encode_def.v.

---
 rtl/multicycle_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multicycle MIPS datapath. Each instruction is sequenced
//   through FETCH / DECODE / EXECUTE / MEM / WB phases, and the single shared
//   ALU is reused for PC+4, the branch target, the load/store address and the
//   result. Memory phases stall until MemReady is high.
//
//   Ports
//     clk, rst_n   rising-edge clock, asynchronous active-low reset
//     Op, Funct    IR[31:26] and IR[5:0]; Op must be valid from DECODE onward
//     Zero         ALU branch condition (already inverted by the ALU for BNE)
//     MemReady     the current memory access completes this cycle
//     AluCtrl      ALU operation code (ALUOp_* encoding, see localparams)
//     ALUSrcA      00 PC, 01 reg A, 10 shamt
//     ALUSrcB      00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
//     ExtOp        1 sign-extend, 0 zero-extend the immediate
//     IorD         memory address select: 0 PC, 1 ALUOut
//     MemRead, MemWrite, IRWrite, PCWr, RegWrite   enables
//     PCSource     00 ALU result, 01 ALUOut, 10 jump target
//     RegDst       1 rd, 0 rt
//     MemtoReg     1 MDR, 0 ALUOut
//     IllegalOp    one-cycle pulse on an unsupported opcode/funct
//     State        current FSM state (debug)
//
//   Handshake: a memory request (MemRead or MemWrite) is held steady while
//   MemReady is low; the cycle in which MemReady is high is the completing
//   cycle and the FSM leaves the memory state on that clock edge.
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Op,
  input  logic [OP_W-1:0]    Funct,
  input  logic               Zero,
  input  logic               MemReady,
  output logic [ALUOP_W-1:0] AluCtrl,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWr,
  output logic [1:0]         PCSource,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               IllegalOp,
  output logic [3:0]         State
);

  // ALUOp_* encodings shared with the ALU.
  localparam logic [ALUOP_W-1:0] ALU_NOP  = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUBU = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(10);
  localparam logic [ALUOP_W-1:0] ALU_BNE  = ALUOP_W'(12);
  localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(17);
  localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(18);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(20);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'b001011);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'b001110);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  localparam logic [OP_W-1:0] FN_SLL   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] FN_SRL   = OP_W'(6'b000010);

  typedef enum logic [3:0] {
    IDLE0    = 4'd0,  FETCH1  = 4'd1,  DECODE2 = 4'd2,  MEMADR3 = 4'd3,
    MEMRD4   = 4'd4,  MEMWB5  = 4'd5,  MEMWR6  = 4'd6,  REXEC7  = 4'd7,
    RWB8     = 4'd8,  BRANCH9 = 4'd9,  JUMP10  = 4'd10, IEXEC11 = 4'd11,
    IWB12    = 4'd12, ILLEGAL13 = 4'd13
  } state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    op_q, funct_q;
  logic [ALUOP_W-1:0] r_alu;
  logic               r_ok;

  // R-type funct decode; r_ok=0 marks an unsupported funct. Used on the raw
  // Funct in DECODE (dispatch) and on the latched funct in REXEC.
  function automatic logic [ALUOP_W:0] rdec(input logic [OP_W-1:0] f);
    case (f)
      OP_W'(6'b100000): rdec = {1'b1, ALU_ADD};
      OP_W'(6'b100001): rdec = {1'b1, ALU_ADDU};
      OP_W'(6'b100010): rdec = {1'b1, ALU_SUB};
      OP_W'(6'b100011): rdec = {1'b1, ALU_SUBU};
      OP_W'(6'b100100): rdec = {1'b1, ALU_AND};
      OP_W'(6'b100101): rdec = {1'b1, ALU_OR};
      OP_W'(6'b100110): rdec = {1'b1, ALU_XOR};
      OP_W'(6'b100111): rdec = {1'b1, ALU_NOR};
      OP_W'(6'b101010): rdec = {1'b1, ALU_SLT};
      OP_W'(6'b101011): rdec = {1'b1, ALU_SLTU};
      FN_SLL:           rdec = {1'b1, ALU_SLL};
      FN_SRL:           rdec = {1'b1, ALU_SRL};
      default:          rdec = {1'b0, ALU_NOP};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE0;
      op_q    <= '0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE2) begin
        op_q    <= Op;
        funct_q <= Funct;
      end
    end
  end

  always_comb begin
    state_d   = IDLE0;
    AluCtrl   = ALU_NOP;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ExtOp     = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWr      = 1'b0;
    PCSource  = 2'b00;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    IllegalOp = 1'b0;
    r_ok      = 1'b0;
    r_alu     = ALU_NOP;

    case (state_q)
      IDLE0: state_d = FETCH1;

      FETCH1: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        AluCtrl = ALU_ADDU;
        IRWrite = MemReady;
        PCWr    = MemReady;
        state_d = MemReady ? DECODE2 : FETCH1;
      end

      DECODE2: begin
        // Branch target PC+4+(imm<<2) is computed speculatively into ALUOut.
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
        AluCtrl = ALU_ADDU;
        {r_ok, r_alu} = rdec(Funct);
        case (Op)
          OP_RTYPE:                  state_d = r_ok ? REXEC7 : ILLEGAL13;
          OP_LW, OP_SW:              state_d = MEMADR3;
          OP_BEQ, OP_BNE:            state_d = BRANCH9;
          OP_J:                      state_d = JUMP10;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                                     state_d = IEXEC11;
          default:                   state_d = ILLEGAL13;
        endcase
      end

      MEMADR3: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        AluCtrl = ALU_ADDU;
        state_d = (op_q == OP_LW) ? MEMRD4 : MEMWR6;
      end

      MEMRD4: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? MEMWB5 : MEMRD4;
      end

      MEMWB5: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = FETCH1;
      end

      MEMWR6: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = MemReady ? FETCH1 : MEMWR6;
      end

      REXEC7: begin
        {r_ok, r_alu} = rdec(funct_q);
        AluCtrl = r_alu;
        ALUSrcA = (funct_q == FN_SLL || funct_q == FN_SRL) ? 2'b10 : 2'b01;
        state_d = r_ok ? RWB8 : ILLEGAL13;
      end

      RWB8: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = FETCH1;
      end

      BRANCH9: begin
        ALUSrcA  = 2'b01;
        PCSource = 2'b01;
        AluCtrl  = (op_q == OP_BNE) ? ALU_BNE : ALU_SUBU;
        PCWr     = Zero;
        state_d  = FETCH1;
      end

      JUMP10: begin
        PCWr     = 1'b1;
        PCSource = 2'b10;
        state_d  = FETCH1;
      end

      IEXEC11: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_ADDI:  begin AluCtrl = ALU_ADD;  ExtOp = 1'b1; end
          OP_ADDIU: begin AluCtrl = ALU_ADDU; ExtOp = 1'b1; end
          OP_SLTI:  begin AluCtrl = ALU_SLT;  ExtOp = 1'b1; end
          OP_SLTIU: begin AluCtrl = ALU_SLTU; ExtOp = 1'b1; end
          OP_ANDI:  AluCtrl = ALU_AND;
          OP_ORI:   AluCtrl = ALU_OR;
          OP_XORI:  AluCtrl = ALU_XOR;
          OP_LUI:   AluCtrl = ALU_LUI;
          default:  AluCtrl = ALU_NOP;
        endcase
        state_d = IWB12;
      end

      IWB12: begin
        RegWrite = 1'b1;
        state_d  = FETCH1;
      end

      ILLEGAL13: begin
        // PC already advanced in FETCH, so simply resume with the next word.
        IllegalOp = 1'b1;
        state_d   = FETCH1;
      end

      default: state_d = IDLE0;
    endcase
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int W = 25;

  localparam logic [4:0] A_NOP = 5'd0,  A_ADDU = 5'd1, A_ADD = 5'd2,
                         A_SUBU = 5'd3, A_OR = 5'd6,   A_BNE = 5'd12,
                         A_SLL = 5'd17;

  localparam logic [9:0] F_EXT  = 10'h200, F_IORD = 10'h100, F_MRD = 10'h080,
                         F_MWR  = 10'h040, F_IRW  = 10'h020, F_PCWR = 10'h010,
                         F_RW   = 10'h008, F_RD   = 10'h004, F_M2R  = 10'h002,
                         F_ILL  = 10'h001;

  logic       clk, rst_n, Zero, MemReady;
  logic [5:0] Op, Funct;
  logic [4:0] AluCtrl;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource;
  logic       ExtOp, IorD, MemRead, MemWrite, IRWrite, PCWr;
  logic       RegWrite, RegDst, MemtoReg, IllegalOp;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  multicycle_ctrl #(.OP_W(6), .ALUOP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .AluCtrl(AluCtrl), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWr(PCWr),
    .PCSource(PCSource), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .IllegalOp(IllegalOp), .State(State)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input logic [3:0] st, input logic [4:0] alu,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] pcs, input logic [9:0] fl);
    ev = {st, alu, a, b, pcs, fl};
  endfunction

  wire [W-1:0] act = {State, AluCtrl, ALUSrcA, ALUSrcB, PCSource, ExtOp, IorD,
                      MemRead, MemWrite, IRWrite, PCWr, RegWrite, RegDst,
                      MemtoReg, IllegalOp};

  // One clock cycle of stimulus: inputs change on the falling edge and the
  // expected output vector for that cycle goes into the scoreboard.
  task automatic cyc(input logic mr, input logic z, input logic [W-1:0] e,
                     input string tag);
    @(negedge clk);
    MemReady = mr;
    Zero     = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn,
                              input string tag);
    Op = op;
    Funct = fn;
    cyc(1'b1, 1'b0, ev(4'd1, A_ADDU, 2'b00, 2'b01, 2'b00, F_MRD | F_IRW | F_PCWR), {tag, ":fetch"});
    cyc(1'b1, 1'b0, ev(4'd2, A_ADDU, 2'b00, 2'b11, 2'b00, F_EXT), {tag, ":decode"});
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (State got %0d expected %0d)",
                 t, act, e, State, e[W-1 -: 4]);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b0; Op = '0; Funct = '0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, ev(4'd0, A_NOP, 0, 0, 0, 10'h0), "reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ev(4'd0, A_NOP, 0, 0, 0, 10'h0));
    tag_q.push_back("idle_after_release");
    #3;
    checks++;
    if (State !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", State);
    end
  endtask

  task automatic test_r_addu();
    fetch_decode(6'b000000, 6'b100001, "addu");
    cyc(1'b1, 1'b0, ev(4'd7, A_ADDU, 2'b01, 2'b00, 2'b00, 10'h0), "addu:rexec");
    cyc(1'b1, 1'b0, ev(4'd8, A_NOP, 0, 0, 0, F_RW | F_RD), "addu:rwb");
  endtask

  task automatic test_lw_stall();
    fetch_decode(6'b100011, 6'b000000, "lw");
    cyc(1'b1, 1'b0, ev(4'd3, A_ADDU, 2'b01, 2'b10, 2'b00, F_EXT), "lw:memadr");
    cyc(1'b0, 1'b0, ev(4'd4, A_NOP, 0, 0, 0, F_IORD | F_MRD), "lw:memrd0");
    cyc(1'b0, 1'b0, ev(4'd4, A_NOP, 0, 0, 0, F_IORD | F_MRD), "lw:memrd1");
    cyc(1'b1, 1'b0, ev(4'd4, A_NOP, 0, 0, 0, F_IORD | F_MRD), "lw:memrd2");
    cyc(1'b1, 1'b0, ev(4'd5, A_NOP, 0, 0, 0, F_RW | F_M2R), "lw:memwb");
  endtask

  task automatic test_sw_random_stall();
    int n;
    n = $urandom_range(0, 3);
    fetch_decode(6'b101011, 6'b000000, "sw");
    cyc(1'b1, 1'b0, ev(4'd3, A_ADDU, 2'b01, 2'b10, 2'b00, F_EXT), "sw:memadr");
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, ev(4'd6, A_NOP, 0, 0, 0, F_IORD | F_MWR), "sw:memwr_wait");
    cyc(1'b1, 1'b0, ev(4'd6, A_NOP, 0, 0, 0, F_IORD | F_MWR), "sw:memwr_done");
  endtask

  task automatic test_fetch_stall();
    Op = 6'b000010;
    cyc(1'b0, 1'b0, ev(4'd1, A_ADDU, 2'b00, 2'b01, 2'b00, F_MRD), "j:fetch_wait");
    fetch_decode(6'b000010, 6'b000000, "j");
    cyc(1'b1, 1'b0, ev(4'd10, A_NOP, 0, 0, 2'b10, F_PCWR), "j:jump");
  endtask

  task automatic test_branches();
    fetch_decode(6'b000100, 6'b000000, "beq");
    cyc(1'b1, 1'b1, ev(4'd9, A_SUBU, 2'b01, 2'b00, 2'b01, F_PCWR), "beq:branch");
    fetch_decode(6'b000101, 6'b000000, "bne");
    cyc(1'b1, 1'b0, ev(4'd9, A_BNE, 2'b01, 2'b00, 2'b01, 10'h0), "bne:branch");
  endtask

  task automatic test_sll_ori_addi();
    fetch_decode(6'b000000, 6'b000000, "sll");
    cyc(1'b1, 1'b0, ev(4'd7, A_SLL, 2'b10, 2'b00, 2'b00, 10'h0), "sll:rexec");
    cyc(1'b1, 1'b0, ev(4'd8, A_NOP, 0, 0, 0, F_RW | F_RD), "sll:rwb");
    fetch_decode(6'b001101, 6'b000000, "ori");
    cyc(1'b1, 1'b0, ev(4'd11, A_OR, 2'b01, 2'b10, 2'b00, 10'h0), "ori:iexec");
    cyc(1'b1, 1'b0, ev(4'd12, A_NOP, 0, 0, 0, F_RW), "ori:iwb");
    fetch_decode(6'b001000, 6'b000000, "addi");
    cyc(1'b1, 1'b0, ev(4'd11, A_ADD, 2'b01, 2'b10, 2'b00, F_EXT), "addi:iexec");
    cyc(1'b1, 1'b0, ev(4'd12, A_NOP, 0, 0, 0, F_RW), "addi:iwb");
  endtask

  task automatic test_illegal_and_mid_reset();
    fetch_decode(6'b111111, 6'b000000, "illegal");
    cyc(1'b1, 1'b0, ev(4'd13, A_NOP, 0, 0, 0, F_ILL), "illegal:pulse");
    fetch_decode(6'b100011, 6'b000000, "lw_rst");
    cyc(1'b1, 1'b0, ev(4'd3, A_ADDU, 2'b01, 2'b10, 2'b00, F_EXT), "lw_rst:memadr");
    cyc(1'b0, 1'b0, ev(4'd4, A_NOP, 0, 0, 0, F_IORD | F_MRD), "lw_rst:memrd");
    @(negedge clk);
    MemReady = 1'b0;
    rst_n = 1'b0;
    exp_q.push_back(ev(4'd0, A_NOP, 0, 0, 0, 10'h0));
    tag_q.push_back("mid_reset");
    #1;
    checks++;
    if (State !== 4'd0 || MemRead !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got State=%0d MemRead=%b expected State=0 MemRead=0",
               State, MemRead);
    end
    cyc(1'b1, 1'b0, ev(4'd0, A_NOP, 0, 0, 0, 10'h0), "mid_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ev(4'd0, A_NOP, 0, 0, 0, 10'h0));
    tag_q.push_back("mid_reset_release");
  endtask

  initial begin
    test_reset();
    test_r_addu();
    test_lw_stall();
    test_branches();
    test_sll_ori_addi();
    test_sw_random_stall();
    test_fetch_stall();
    test_illegal_and_mid_reset();
    cyc(1'b1, 1'b0, ev(4'd1, A_ADDU, 2'b00, 2'b01, 2'b00, F_MRD | F_IRW | F_PCWR), "final_fetch");
    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
